adder_40_rr_arbiter: RTL and testbench

//  Shares one combinational adder_40_bit between N_REQ requesters (Dadda final-stage adds, accumulators).

---
 rtl/adder_40_rr_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_adder_40_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_40_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_40_bit
//   Purely combinational WIDTH-bit adder with carry in and carry out.
//   Ports:
//     a, b  in   WIDTH  operands
//     cin   in   1      carry in
//     sum   out  WIDTH  low WIDTH bits of a + b + cin
//     cout  out  1      carry out (bit WIDTH of the full sum)
//
// adder_40_rr_arbiter
//   Shares a single adder_40_bit instance between N_REQ requesters.
//   A round-robin search picks one requester per cycle. Its operands go
//   through the adder, and the result lands in a one-entry result register
//   tagged with the requester index.
//   Ports:
//     clk        in   1              rising-edge clock
//     rst_n      in   1              asynchronous active-low reset
//     req_valid  in   N_REQ          requester i has an operand pair pending
//     req_ready  out  N_REQ          one-hot grant (all zero when nothing granted)
//     req_a      in   N_REQ*D_WIDTH  operand A, slice i = [i*D_WIDTH +: D_WIDTH]
//     req_b      in   N_REQ*D_WIDTH  operand B, same slicing
//     req_cin    in   N_REQ          carry in per requester
//     rsp_valid  out  1              result register holds a result (slot state)
//     rsp_ready  in   1              consumer takes the result
//     rsp_sum    out  D_WIDTH        registered sum
//     rsp_cout   out  1              registered carry out
//     rsp_id     out  ID_W           index of the requester that produced the sum
//
//   Handshake: a transfer happens on an edge where valid and ready are both
//   high. On the request side this is req_valid[i] & req_ready[i]. On the
//   response side it is rsp_valid & rsp_ready. Ready may depend on the
//   current slot state and on the consumer's rsp_ready, but never on the
//   granted requester's own valid except through the priority search.
// -----------------------------------------------------------------------------

module adder_40_bit #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum  = full_sum[WIDTH-1:0];
    assign cout = full_sum[WIDTH];

endmodule

module adder_40_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 40,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]   req_a,
    input  logic [N_REQ*D_WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]           req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [D_WIDTH-1:0]         rsp_sum,
    output logic                       rsp_cout,
    output logic [ID_W-1:0]            rsp_id
);

    // The result slot is the only control state. rsp_valid is a direct
    // decode of it, so the slot state is visible on the port.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t        slot_q;
    slot_state_t        slot_d;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;
    logic               can_accept;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;

    logic [D_WIDTH-1:0] add_a;
    logic [D_WIDTH-1:0] add_b;
    logic               add_cin;
    logic [D_WIDTH-1:0] add_sum;
    logic               add_cout;

    assign rsp_valid = (slot_q == SLOT_FULL);

    // The slot can take a new result when it is empty or draining this
    // edge. Reset is folded in so req_ready stays low while rst_n is low.
    assign can_accept = rst_n & (~rsp_valid | rsp_ready);

    // ------------------------------------------------------------------
    // Round-robin search: offset k visits rr_ptr+k mod N_REQ. The inner
    // loop compares against constant indices, which keeps the selects
    // static and lets N_REQ be any value, not only a power of two.
    // ------------------------------------------------------------------
    always_comb begin : grant_search
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (can_accept) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (!grant_found && (i == idx) && req_valid[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = ID_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant_found && (grant_idx == ID_W'(i));
        end
    end

    // Operand mux into the shared adder. AND-OR style: at most one grant
    // bit is set, and with no grant the adder sees zeros.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                add_a   = req_a[i*D_WIDTH +: D_WIDTH];
                add_b   = req_b[i*D_WIDTH +: D_WIDTH];
                add_cin = req_cin[i];
            end
        end
    end

    adder_40_bit #(
        .WIDTH (D_WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The winner moves to lowest priority: the pointer lands just past it.
    always_comb begin
        if (grant_idx == ID_W'(N_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx + ID_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SLOT_EMPTY: begin
                if (grant_found) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // A grant while full implies rsp_ready: drain and refill
                // on the same edge.
                if (grant_found) begin
                    slot_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and round-robin pointer. These load only on an
    // accept, so they hold under backpressure and while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
        end else if (grant_found) begin
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
            rsp_id   <= grant_idx;
            rr_ptr   <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_adder_40_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for adder_40_rr_arbiter (N_REQ=4, D_WIDTH=40, ID_W=2).
// The driver applies stimulus just after each rising edge. A reference
// model then predicts the grant at the negative edge, checks req_ready,
// and pushes the expected tagged result into exp_q. A separate monitor
// compares the presented result against the head of exp_q at every
// negative edge, and pops the entry when the consumer takes it.
// -----------------------------------------------------------------------------

module tb_adder_40_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 40;
    localparam int IDW = 2;
    localparam int EW  = IDW + 1 + DW;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_cin;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_sum;
    logic            rsp_cout;
    logic [IDW-1:0]  rsp_id;

    adder_40_rr_arbiter #(
        .N_REQ   (N),
        .D_WIDTH (DW),
        .ID_W    (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;
    bit            mon_en;
    int            model_ptr;
    bit            model_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_ops();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0:       a = '1;
                1:       a = '0;
                default: a = DW'({$urandom, $urandom});
            endcase
            case ($urandom_range(0, 7))
                0:       b = '1;
                1:       b = '0;
                default: b = DW'({$urandom, $urandom});
            endcase
            req_a[i*DW +: DW] = a;
            req_b[i*DW +: DW] = b;
        end
        req_cin = N'($urandom);
    endtask

    // Reference model: search priority from the pointer, and add with
    // plain 64-bit arithmetic.
    task automatic model_step();
        int                g;
        int                idx;
        logic [N-1:0]      exp_rdy;
        longint unsigned   full;
        logic [DW-1:0]     a;
        logic [DW-1:0]     b;
        g       = -1;
        exp_rdy = '0;
        if (!model_full || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0) begin
            a    = req_a[g*DW +: DW];
            b    = req_b[g*DW +: DW];
            full = longint'(a) + longint'(b) + longint'(req_cin[g]);
            exp_q.push_back({IDW'(g), full[DW], full[DW-1:0]});
            model_ptr  = (g + 1) % N;
            model_full = 1'b1;
        end else if (rsp_ready) begin
            model_full = 1'b0;
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input bit rdy, input bit rnd);
        @(posedge clk);
        #1;
        req_valid = v;
        rsp_ready = rdy;
        if (rnd) rand_ops();
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        mon_en     = 1'b0;
        req_valid  = '0;
        exp_q.delete();
        model_ptr  = 0;
        model_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (mon_en) begin
            check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("rsp_id", 64'(rsp_id), 64'(e[EW-1 -: IDW]));
                check("rsp_cout", 64'(rsp_cout), 64'(e[DW]));
                check("rsp_sum", 64'(rsp_sum), 64'(e[DW-1:0]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        model_ptr  = 0;
        model_full = 1'b0;
        rst_n      = 1'b0;
        req_valid  = '1;
        rsp_ready  = 1'b0;
        rand_ops();

        // Reset with every requester asking.
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
        check("reset_rsp_cout", 64'(rsp_cout), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));

        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        mon_en    = 1'b1;

        // Single add: all-ones + 1 wraps to zero with carry out.
        req_a[0*DW +: DW] = 40'hFF_FFFF_FFFF;
        req_b[0*DW +: DW] = 40'h1;
        req_cin           = 4'b0000;
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        // All-ones + 0 + carry-in 1 on requester 1.
        req_a[1*DW +: DW] = 40'hFF_FFFF_FFFF;
        req_b[1*DW +: DW] = 40'h0;
        req_cin           = 4'b0010;
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1);

        // Round robin from a fresh pointer: ids 0,1,2,3,0,1,2.
        do_reset();
        repeat (7) cycle(4'b1111, 1'b1, 1'b1);

        // Backpressure for 3 cycles, then a grant in the release cycle.
        repeat (3) cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);

        // Bring the pointer to 3, then only req1 and req3: 3,1,3.
        repeat (3) cycle(4'b1111, 1'b1, 1'b1);
        repeat (3) cycle(4'b1010, 1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        repeat (2) cycle(4'b0000, 1'b1, 1'b1);

        // Async reset while a result is held.
        cycle(4'b0001, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("async_rst_rsp_sum", 64'(rsp_sum), 64'(0));
        check("async_rst_req_ready", 64'(req_ready), 64'(0));
        exp_q.delete();
        model_ptr  = 0;
        model_full = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 4'b0101;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        model_step();
        repeat (3) cycle(4'b0000, 1'b1, 1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
